// File: rtl/delay_sound_timers_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : delay_sound_timers_pkg                                        |
// | Brief    : Shared types, select encodings and sizing helpers for the     |
// |            CHIP-8 delay/sound timer block.                               |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef TIMER_SEL_DT
`define TIMER_SEL_DT (1'b0)
`endif
`ifndef TIMER_SEL_ST
`define TIMER_SEL_ST (1'b1)
`endif

package delay_sound_timers_pkg;

  typedef logic [7:0] timer_t;

  // Register select encodings seen on wr_sel (FX15 -> DT, FX18 -> ST)
  localparam logic c_SEL_DT = `TIMER_SEL_DT;
  localparam logic c_SEL_ST = `TIMER_SEL_ST;

  // Half period of the buzzer tone in clock cycles, never below one cycle
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned tone_hz);
    int unsigned hp;
    if (tone_hz == 0) return 1;
    hp = clk_hz / (2 * tone_hz);
    return (hp < 1) ? 1 : hp;
  endfunction

  // Counter width able to hold 0 .. hp-1
  function automatic int unsigned cnt_width(input int unsigned hp);
    return (hp > 1) ? $clog2(hp) : 1;
  endfunction

  // One 60 Hz step of a timer: count down, saturate at zero
  function automatic timer_t tick_dec(input timer_t v, input logic tick);
    return (tick && (v != '0)) ? timer_t'(v - 8'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_sound_timers_tone_gen.sv
// ---------------------------------------------------------------------------
// | Module   : tone_gen                                                      |
// | Brief    : Square-wave generator; toggles every HALF_PERIOD cycles while |
// |            enabled, parked low with a cleared phase when disabled.       |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tone_gen
  import delay_sound_timers_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic wave
);

  localparam int unsigned c_HP   = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
  localparam int unsigned c_CW   = cnt_width(c_HP);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_HP - 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_wave;

  // Phase counter and output level; disabling restarts the phase from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (r_cnt == c_LAST) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + c_CW'(1);
    end
  end

  assign wave = r_wave;

endmodule

`default_nettype wire

// File: rtl/delay_sound_timers.sv
// ---------------------------------------------------------------------------
// | Module   : delay_sound_timers                                            |
// | Brief    : CHIP-8 delay (DT) and sound (ST) timers, decremented by the   |
// |            60 Hz tick, with a square-wave buzzer while ST is sounding.   |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50000000
`endif

module delay_sound_timers
  import delay_sound_timers_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = `CLOCK_SPEED,
  parameter int unsigned TONE_HZ     = 440,
  parameter int unsigned SOUND_MIN   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_60hz,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] dt_value,
  output logic       dt_zero,
  output logic       sound_active,
  output logic       buzzer
);

  localparam int unsigned c_HALF_PERIOD = half_period(CLOCK_SPEED, TONE_HZ);

  timer_t r_dt;
  timer_t r_st;
  logic   w_wr_dt;
  logic   w_wr_st;
  logic   w_sound;
  logic   w_wave;

  assign w_wr_dt = wr_en && (wr_sel == c_SEL_DT);
  assign w_wr_st = wr_en && (wr_sel == c_SEL_ST);

  // Delay timer: a CPU load overrides the tick for this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_dt <= '0;
    else if (w_wr_dt) r_dt <= wr_data;
    else              r_dt <= tick_dec(r_dt, tick_60hz);
  end

  // Sound timer: same load/tick priority as the delay timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_st <= '0;
    else if (w_wr_st) r_st <= wr_data;
    else              r_st <= tick_dec(r_st, tick_60hz);
  end

  // Status flags come straight from the registers, no extra stage
  assign w_sound      = (32'(r_st) >= SOUND_MIN);
  assign dt_value     = r_dt;
  assign dt_zero      = (r_dt == '0);
  assign sound_active = w_sound;

  tone_gen #(
    .HALF_PERIOD (c_HALF_PERIOD)
  ) u_tone_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_sound),
    .wave    (w_wave)
  );

  assign buzzer = w_wave;

endmodule

`default_nettype wire

// File: tb/tb_delay_sound_timers.sv
// ---------------------------------------------------------------------------
// | Module   : tb_delay_sound_timers                                         |
// | Brief    : Self-checking bench; two instances (SOUND_MIN 1 and 2) share  |
// |            stimulus and are compared against a behavioural model.        |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_delay_sound_timers;

  localparam int c_HP = 5;  // 1000 Hz / (2 * 100 Hz)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_60hz = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;

  logic [7:0] dtv  [2];
  logic       dtz  [2];
  logic       snd  [2];
  logic       buz  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: timer values as integers, buzzer from time spent sounding
  int m_dt = 0;
  int m_st = 0;
  int m_k [2] = '{0, 0};
  int smin [2] = '{1, 2};

  always #5 clk = ~clk;

  delay_sound_timers #(.CLOCK_SPEED(1000), .TONE_HZ(100), .SOUND_MIN(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tick_60hz(tick_60hz), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .dt_value(dtv[0]), .dt_zero(dtz[0]),
    .sound_active(snd[0]), .buzzer(buz[0])
  );

  delay_sound_timers #(.CLOCK_SPEED(1000), .TONE_HZ(100), .SOUND_MIN(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tick_60hz(tick_60hz), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_data(wr_data), .dt_value(dtv[1]), .dt_zero(dtz[1]),
    .sound_active(snd[1]), .buzzer(buz[1])
  );

  task automatic model_reset();
    m_dt = 0; m_st = 0; m_k[0] = 0; m_k[1] = 0;
  endtask

  // One clock edge of the model: k counts edges spent sounding since the tone started
  task automatic model_edge(input logic we, input logic sel, input logic [7:0] d, input logic tk);
    for (int m = 0; m < 2; m++)
      m_k[m] = (m_st >= smin[m]) ? m_k[m] + 1 : 0;
    if (we && !sel)         m_dt = d;
    else if (tk && m_dt > 0) m_dt = m_dt - 1;
    if (we && sel)          m_st = d;
    else if (tk && m_st > 0) m_st = m_st - 1;
  endtask

  function automatic logic exp_buz(input int m);
    return ((m_k[m] / c_HP) % 2) == 1;
  endfunction

  // Drive one cycle of inputs, advance the model, return 1 time unit past the edge
  task automatic cycle(input logic we, input logic sel, input logic [7:0] d, input logic tk);
    wr_en = we; wr_sel = sel; wr_data = d; tick_60hz = tk;
    @(posedge clk);
    model_edge(we, sel, d, tk);
    #1;
    wr_en = 1'b0; tick_60hz = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    cycle(0, 0, 8'd0, 0);
    for (int m = 0; m < 2; m++) begin
      n_cmp += 4;
      if (dtv[m] !== 8'd0) begin n_bad++; $display("FAIL reset_dt[%0d]: got %0d want 0", m, dtv[m]); end
      if (dtz[m] !== 1'b1) begin n_bad++; $display("FAIL reset_dtz[%0d]: got %b want 1", m, dtz[m]); end
      if (snd[m] !== 1'b0) begin n_bad++; $display("FAIL reset_snd[%0d]: got %b want 0", m, snd[m]); end
      if (buz[m] !== 1'b0) begin n_bad++; $display("FAIL reset_buz[%0d]: got %b want 0", m, buz[m]); end
    end
  endtask

  task automatic test_dt_countdown();
    logic [7:0] exp_v [4] = '{8'd2, 8'd1, 8'd0, 8'd0};
    logic       exp_z [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    cycle(1, 0, 8'd3, 0);
    n_cmp += 2;
    if (dtv[0] !== 8'd3) begin n_bad++; $display("FAIL dt_load: got %0d want 3", dtv[0]); end
    if (dtz[0] !== 1'b0) begin n_bad++; $display("FAIL dt_load_zero: got %b want 0", dtz[0]); end
    for (int t = 0; t < 4; t++) begin
      repeat (9) cycle(0, 0, 8'd0, 0);
      cycle(0, 0, 8'd0, 1);
      n_cmp += 2;
      if (dtv[0] !== exp_v[t]) begin n_bad++; $display("FAIL dt_tick%0d: got %0d want %0d", t, dtv[0], exp_v[t]); end
      if (dtz[0] !== exp_z[t]) begin n_bad++; $display("FAIL dt_zero%0d: got %b want %b", t, dtz[0], exp_z[t]); end
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_dt [3] = '{8'd8, 8'd7, 8'd6};
    logic       exp_s  [3] = '{1'b1, 1'b1, 1'b0};
    cycle(1, 0, 8'd5, 0);
    cycle(1, 1, 8'd4, 0);
    cycle(1, 0, 8'd9, 1);   // DT write collides with tick; ST 4 -> 3
    n_cmp += 2;
    if (dtv[0] !== 8'd9) begin n_bad++; $display("FAIL coll_dt: got %0d want 9", dtv[0]); end
    if (snd[0] !== 1'b1) begin n_bad++; $display("FAIL coll_snd: got %b want 1", snd[0]); end
    // ST must reach zero after exactly three more ticks
    for (int t = 0; t < 3; t++) begin
      cycle(0, 0, 8'd0, 1);
      n_cmp += 2;
      if (dtv[0] !== exp_dt[t]) begin n_bad++; $display("FAIL coll_dt%0d: got %0d want %0d", t, dtv[0], exp_dt[t]); end
      if (snd[0] !== exp_s[t]) begin n_bad++; $display("FAIL coll_st%0d: got %b want %b", t, snd[0], exp_s[t]); end
    end
    repeat (2) cycle(0, 0, 8'd0, 0);
  endtask

  task automatic test_buzzer();
    cycle(1, 1, 8'd2, 0);
    n_cmp += 3;
    if (snd[0] !== 1'b1) begin n_bad++; $display("FAIL buz_snd0: got %b want 1", snd[0]); end
    if (snd[1] !== 1'b1) begin n_bad++; $display("FAIL buz_snd1: got %b want 1", snd[1]); end
    if (buz[0] !== 1'b0) begin n_bad++; $display("FAIL buz_start: got %b want 0", buz[0]); end
    for (int n = 1; n <= 5; n++) begin
      cycle(0, 0, 8'd0, 0);
      n_cmp++;
      if (buz[0] !== (n == 5)) begin n_bad++; $display("FAIL buz_cyc%0d: got %b want %b", n, buz[0], (n == 5)); end
    end
    cycle(0, 0, 8'd0, 1);   // ST 2 -> 1
    n_cmp += 3;
    if (snd[0] !== 1'b1) begin n_bad++; $display("FAIL buz_t1_snd0: got %b want 1", snd[0]); end
    if (snd[1] !== 1'b0) begin n_bad++; $display("FAIL buz_t1_snd1: got %b want 0", snd[1]); end
    if (buz[0] !== 1'b1) begin n_bad++; $display("FAIL buz_t1_buz0: got %b want 1", buz[0]); end
    cycle(0, 0, 8'd0, 0);
    n_cmp += 2;
    if (buz[1] !== 1'b0) begin n_bad++; $display("FAIL buz_off1: got %b want 0", buz[1]); end
    if (buz[0] !== 1'b1) begin n_bad++; $display("FAIL buz_hold0: got %b want 1", buz[0]); end
    cycle(0, 0, 8'd0, 1);   // ST 1 -> 0
    n_cmp++;
    if (snd[0] !== 1'b0) begin n_bad++; $display("FAIL buz_t2_snd0: got %b want 0", snd[0]); end
    cycle(0, 0, 8'd0, 0);
    n_cmp++;
    if (buz[0] !== 1'b0) begin n_bad++; $display("FAIL buz_off0: got %b want 0", buz[0]); end
  endtask

  task automatic test_sound_min2();
    cycle(1, 1, 8'd1, 0);
    n_cmp += 2;
    if (snd[1] !== 1'b0) begin n_bad++; $display("FAIL smin_st1_snd1: got %b want 0", snd[1]); end
    if (snd[0] !== 1'b1) begin n_bad++; $display("FAIL smin_st1_snd0: got %b want 1", snd[0]); end
    for (int n = 1; n <= 6; n++) begin
      cycle(0, 0, 8'd0, 0);
      n_cmp += 2;
      if (buz[1] !== 1'b0) begin n_bad++; $display("FAIL smin_buz1_%0d: got %b want 0", n, buz[1]); end
      if (buz[0] !== (n >= 5)) begin n_bad++; $display("FAIL smin_buz0_%0d: got %b want %b", n, buz[0], (n >= 5)); end
    end
    cycle(1, 1, 8'd2, 0);
    n_cmp++;
    if (snd[1] !== 1'b1) begin n_bad++; $display("FAIL smin_st2_snd1: got %b want 1", snd[1]); end
    cycle(0, 0, 8'd0, 1);
    n_cmp++;
    if (snd[1] !== 1'b0) begin n_bad++; $display("FAIL smin_tick_snd1: got %b want 0", snd[1]); end
    cycle(0, 0, 8'd0, 1);
    repeat (2) cycle(0, 0, 8'd0, 0);
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 8'd200, 0);
    cycle(1, 1, 8'd50, 0);
    repeat (6) cycle(0, 0, 8'd0, 0);
    n_cmp += 2;
    if (dtv[0] !== 8'd200) begin n_bad++; $display("FAIL ar_pre_dt: got %0d want 200", dtv[0]); end
    if (buz[0] !== 1'b1) begin n_bad++; $display("FAIL ar_pre_buz: got %b want 1", buz[0]); end
    #2;
    reset_n = 1'b0;   // between clock edges
    #1;
    for (int m = 0; m < 2; m++) begin
      n_cmp += 4;
      if (dtv[m] !== 8'd0) begin n_bad++; $display("FAIL ar_dt[%0d]: got %0d want 0", m, dtv[m]); end
      if (dtz[m] !== 1'b1) begin n_bad++; $display("FAIL ar_dtz[%0d]: got %b want 1", m, dtz[m]); end
      if (snd[m] !== 1'b0) begin n_bad++; $display("FAIL ar_snd[%0d]: got %b want 0", m, snd[m]); end
      if (buz[m] !== 1'b0) begin n_bad++; $display("FAIL ar_buz[%0d]: got %b want 0", m, buz[m]); end
    end
    tick_60hz = 1'b1;   // lost while in reset
    @(posedge clk);
    #1;
    tick_60hz = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) cycle(0, 0, 8'd0, 1);
    n_cmp += 2;
    if (dtv[0] !== 8'd0) begin n_bad++; $display("FAIL ar_post_dt: got %0d want 0", dtv[0]); end
    if (dtz[0] !== 1'b1) begin n_bad++; $display("FAIL ar_post_dtz: got %b want 1", dtz[0]); end
  endtask

  task automatic test_random();
    int burst = 0;
    logic we, sel, tk;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 4) == 0);
      sel = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 24));
      if (burst > 0) begin tk = 1'b1; burst--; end
      else begin
        tk = ($urandom_range(0, 6) == 0);
        if (tk && $urandom_range(0, 9) == 0) burst = 2;  // held-high tick
      end
      cycle(we, sel, d, tk);
      for (int m = 0; m < 2; m++) begin
        n_cmp += 4;
        if (dtv[m] !== 8'(m_dt)) begin n_bad++; $display("FAIL rnd%0d_dt[%0d]: got %0d want %0d", i, m, dtv[m], m_dt); end
        if (dtz[m] !== (m_dt == 0)) begin n_bad++; $display("FAIL rnd%0d_dtz[%0d]: got %b want %b", i, m, dtz[m], (m_dt == 0)); end
        if (snd[m] !== (m_st >= smin[m])) begin n_bad++; $display("FAIL rnd%0d_snd[%0d]: got %b want %b", i, m, snd[m], (m_st >= smin[m])); end
        if (buz[m] !== exp_buz(m)) begin n_bad++; $display("FAIL rnd%0d_buz[%0d]: got %b want %b", i, m, buz[m], exp_buz(m)); end
      end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dt_countdown();
    test_collision();
    test_buzzer();
    test_sound_min2();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
